out_req_upload_fifo: RTL and testbench
======================================

Name: out_req_upload_fifo

Overview:
- Downstream stage of the OUT_req upload arbiter; sits between the inst_cache/data_cache/memory upload registers and the ring-network request port.
- On each arbiter ack, captures the flit and ctrl from the source chosen by the one-hot select into a flit FIFO, and raises OUT_req_rdy while space remains.
- Drains whole packets to the network port (store-and-forward) under a valid/ready handshake; ctrl 2'b11 marks the tail flit.

Parameters:
FLIT_W, 16, flit data width
DEPTH, 8, FIFO entries (power of two, >=2)
AW, 3, log2(DEPTH); pointer width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ack_OUT_req  in  1  write strobe from arbiter
select  in  3  one-hot source: [2]=ic, [1]=dc, [0]=mem
ic_flit_in  in  FLIT_W  ic upload flit
dc_flit_in  in  FLIT_W  dc upload flit
mem_flit_in  in  FLIT_W  mem upload flit
ic_ctrl_in  in  2  ic flit ctrl
dc_ctrl_in  in  2  dc flit ctrl
mem_ctrl_in  in  2  mem flit ctrl
OUT_req_rdy  out  1  FIFO can accept a flit this cycle
v_flit_out  out  1  flit valid to network
flit_out  out  FLIT_W  head-of-FIFO flit
ctrl_out  out  2  head-of-FIFO ctrl
net_rdy  in  1  network accepts flit
protocol_err  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: wr_ptr=rd_ptr=0, count=0, pkt_cnt=0, state=OUT_IDLE, protocol_err=0. While rst=1: OUT_req_rdy=0, v_flit_out=0. flit_out/ctrl_out=0 when the FIFO is empty.
- OUT_req_rdy = !rst && count<DEPTH. It is combinational from registered count, with no same-cycle bypass from reads.
- Write: when ack_OUT_req=1, OUT_req_rdy=1 and select is one-hot, write the selected {ctrl,flit} at wr_ptr. Then wr_ptr++ (wraps modulo DEPTH) and count++.
- Write violations: ack_OUT_req=1 with select not one-hot, or with count==DEPTH, writes nothing and sets protocol_err (held until rst).
- Packet counter: pkt_cnt (AW+1 bits) counts complete packets (tails) held in the FIFO.
  - Writing a tail (ctrl 2'b11) increments it; popping a tail decrements it; both in the same cycle leaves it unchanged.
- Read is first-word fall-through: flit_out/ctrl_out always show the entry at rd_ptr.
- Pop occurs when v_flit_out && net_rdy. Pop does rd_ptr++ (wraps) and count--. A simultaneous write and pop leaves count unchanged.
- Output FSM:
  - OUT_IDLE: v_flit_out=0. If pkt_cnt>0, next state is OUT_SEND.
  - OUT_SEND: v_flit_out = count>0. On a pop with ctrl_out==2'b11, next state is OUT_IDLE; otherwise stay.
  - flit_out/ctrl_out must hold stable while v_flit_out=1 && net_rdy=0.
- Latency: tail written in cycle T -> pkt_cnt=1 at T+1 -> v_flit_out=1 at T+2 (head flit). Flits then stream at one per cycle while net_rdy=1.
- Back-to-back packets: after a tail pop, the FSM returns to OUT_IDLE for one cycle (v_flit_out=0) before starting the next stored packet.
- Full FIFO with no complete packet (deadlock-prone sizing) is not resolved by this block. Packets longer than DEPTH flits are illegal in store-and-forward mode.

Optional Feature:
OUT_REQ_CUT_THROUGH_EN
- Defined: OUT_IDLE moves to OUT_SEND when count>0 and ctrl_out==2'b01 (head flit), without waiting for the tail. In OUT_SEND, v_flit_out=count>0, so the output stalls (v=0) if the FIFO empties mid-packet. pkt_cnt is still maintained but not used for gating. Packets longer than DEPTH are legal.
- Undefined: store-and-forward as described above.

Test Plan:
- Reset then idle -> OUT_req_rdy=1 on the first cycle after rst falls; v_flit_out=0; protocol_err=0.
- dc writes a 4-flit packet (ctrl 01,10,10,11) on consecutive cycles, net_rdy=1 -> v_flit_out first rises 2 cycles after the tail write; 4 flits emitted in order; FSM back in OUT_IDLE.
- Write 8 flits (two 4-flit packets, ic then mem) with net_rdy=0 -> OUT_req_rdy=0 when count=8. A further ack_OUT_req sets protocol_err=1 and FIFO contents are unchanged. Releasing net_rdy then drains all 8 flits with a 1-cycle gap between packets; wr_ptr/rd_ptr wrap correctly.
- Toggle net_rdy every cycle during a packet -> flit_out is stable while stalled; no flit is dropped or duplicated.
- Simultaneous tail write and tail pop -> pkt_cnt unchanged; count unchanged.
- With OUT_REQ_CUT_THROUGH_EN defined: write only a head flit -> v_flit_out=1 two cycles later. The FIFO then empties -> v_flit_out=0 until the next body flit arrives.

Source files
------------

// File: rtl/out_req_upload_fifo.sv
// Flit FIFO between the OUT_req upload arbiter and the ring request port.
// Store-and-forward by default; define OUT_REQ_CUT_THROUGH_EN to start on the head flit.
module out_req_upload_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack_OUT_req,
  input  logic [2:0]        select,
  input  logic [FLIT_W-1:0] ic_flit_in,
  input  logic [FLIT_W-1:0] dc_flit_in,
  input  logic [FLIT_W-1:0] mem_flit_in,
  input  logic [1:0]        ic_ctrl_in,
  input  logic [1:0]        dc_ctrl_in,
  input  logic [1:0]        mem_ctrl_in,
  output logic              OUT_req_rdy,
  output logic              v_flit_out,
  output logic [FLIT_W-1:0] flit_out,
  output logic [1:0]        ctrl_out,
  input  logic              net_rdy,
  output logic              protocol_err
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0]  CTRL_HEAD = 2'b01;
  localparam logic [1:0]  CTRL_TAIL = 2'b11;

  typedef enum logic {OUT_IDLE, OUT_SEND} state_t;

  logic [FLIT_W+1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, pkt_cnt;
  state_t            state, state_nxt;

  logic              sel_ok, full, nonempty, wr_en, pop, wr_tail, pop_tail, bad_wr;
  logic [FLIT_W-1:0] wr_flit;
  logic [1:0]        wr_ctrl;

  assign sel_ok   = $onehot(select);
  assign full     = (count == FULL);
  assign nonempty = (count != '0);

  assign wr_flit = ({FLIT_W{select[2]}} & ic_flit_in)
                 | ({FLIT_W{select[1]}} & dc_flit_in)
                 | ({FLIT_W{select[0]}} & mem_flit_in);
  assign wr_ctrl = ({2{select[2]}} & ic_ctrl_in)
                 | ({2{select[1]}} & dc_ctrl_in)
                 | ({2{select[0]}} & mem_ctrl_in);

  // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
  assign OUT_req_rdy = !rst && !full;
  assign wr_en       = ack_OUT_req && OUT_req_rdy && sel_ok;
  assign bad_wr      = ack_OUT_req && (!sel_ok || full);

  assign flit_out   = nonempty ? mem[rd_ptr][FLIT_W-1:0] : '0;
  assign ctrl_out   = nonempty ? mem[rd_ptr][FLIT_W+1:FLIT_W] : '0;
  assign v_flit_out = !rst && (state == OUT_SEND) && nonempty;
  assign pop        = v_flit_out && net_rdy;

  assign wr_tail  = wr_en && (wr_ctrl == CTRL_TAIL);
  assign pop_tail = pop && (ctrl_out == CTRL_TAIL);

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {wr_ctrl, wr_flit};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pkt_cnt      <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({wr_tail, pop_tail})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (bad_wr) protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= OUT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_IDLE: begin
`ifdef OUT_REQ_CUT_THROUGH_EN
        if (nonempty && (ctrl_out == CTRL_HEAD)) state_nxt = OUT_SEND;
`else
        if (pkt_cnt != '0) state_nxt = OUT_SEND;
`endif
      end
      OUT_SEND: if (pop_tail) state_nxt = OUT_IDLE;
      default:  state_nxt = OUT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_out_req_upload_fifo.sv
// Scoreboard bench for out_req_upload_fifo: accepted writes queue up as expected
// output flits; a negedge monitor checks ready/error/head and retires popped flits.
module tb_out_req_upload_fifo;
  localparam int FLIT_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0, rst = 1'b1, ack = 1'b0, net_rdy = 1'b0;
  logic [2:0]        select = '0;
  logic [FLIT_W-1:0] ic_flit_in = '0, dc_flit_in = '0, mem_flit_in = '0;
  logic [1:0]        ic_ctrl_in = '0, dc_ctrl_in = '0, mem_ctrl_in = '0;
  logic              out_req_rdy, v_flit_out, protocol_err;
  logic [FLIT_W-1:0] flit_out;
  logic [1:0]        ctrl_out;

  always #5 clk = ~clk;

  out_req_upload_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ack_OUT_req(ack), .select(select),
    .ic_flit_in(ic_flit_in), .dc_flit_in(dc_flit_in), .mem_flit_in(mem_flit_in),
    .ic_ctrl_in(ic_ctrl_in), .dc_ctrl_in(dc_ctrl_in), .mem_ctrl_in(mem_ctrl_in),
    .OUT_req_rdy(out_req_rdy), .v_flit_out(v_flit_out), .flit_out(flit_out),
    .ctrl_out(ctrl_out), .net_rdy(net_rdy), .protocol_err(protocol_err)
  );

  logic [FLIT_W+1:0] exp_q[$];
  bit pend_wr, exp_err, exp_err_nxt, gap;
  int ncmp, nfail, pos, len;
  bit acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit a, input logic [2:0] s, input logic [1:0] c,
                      input logic [FLIT_W-1:0] f, input bit nr, output bit ok);
    @(posedge clk); #1;
    exp_err = exp_err_nxt;
    pend_wr = 0;
    ok = 0;
    ack = a; select = s; net_rdy = nr;
    ic_flit_in  = FLIT_W'($urandom); dc_flit_in  = FLIT_W'($urandom); mem_flit_in = FLIT_W'($urandom);
    ic_ctrl_in  = 2'($urandom);      dc_ctrl_in  = 2'($urandom);      mem_ctrl_in = 2'($urandom);
    if (s == 3'b100) begin ic_flit_in  = f; ic_ctrl_in  = c; end
    if (s == 3'b010) begin dc_flit_in  = f; dc_ctrl_in  = c; end
    if (s == 3'b001) begin mem_flit_in = f; mem_ctrl_in = c; end
    if (a && !rst) begin
      if ($onehot(s) && exp_q.size() < DEPTH) begin
        exp_q.push_back({c, f});
        pend_wr = 1;
        ok = 1;
      end else exp_err_nxt = 1;
    end
  endtask

  task automatic idle(input bit nr);
    bit d;
    step(0, 3'b000, 2'b00, '0, nr, d);
  endtask

  task automatic wr_pkt(input logic [2:0] s, input int n, input bit nr);
    bit d;
    for (int i = 0; i < n; i++)
      step(1, s, (i == 0) ? 2'b01 : (i == n-1) ? 2'b11 : 2'b10, FLIT_W'($urandom), nr, d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; ack = 0; net_rdy = 0;
    exp_q.delete(); pend_wr = 0; exp_err = 0; exp_err_nxt = 0; pos = 0; len = 3;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  function automatic logic [1:0] next_ctrl();
    return (pos == 0) ? 2'b01 : (pos == len-1) ? 2'b11 : 2'b10;
  endfunction

  // Monitor: registered-state checks plus retirement of each handshaked flit.
  always @(negedge clk) begin
    int  stored;
    bit  has_tail;
    if (rst) begin
      chk("rdy_in_rst", out_req_rdy, 0);
      chk("v_in_rst", v_flit_out, 0);
      gap = 0;
    end else begin
      stored = exp_q.size() - int'(pend_wr);
      chk("rdy", out_req_rdy, (stored < DEPTH) ? 1 : 0);
      chk("protocol_err", protocol_err, exp_err);
      if (stored > 0) chk("head_flit", {ctrl_out, flit_out}, exp_q[0]);
      else            chk("empty_out", {ctrl_out, flit_out}, 0);
      if (gap) chk("pkt_gap_v", v_flit_out, 0);
      gap = 0;
      if (v_flit_out) begin
        chk("v_nonempty", (stored > 0) ? 1 : 0, 1);
`ifndef OUT_REQ_CUT_THROUGH_EN
        has_tail = 0;
        for (int i = 0; i < stored; i++)
          if (exp_q[i][FLIT_W+1:FLIT_W] == 2'b11) has_tail = 1;
        chk("sf_whole_pkt", has_tail, 1);
`endif
        if (net_rdy && stored > 0) begin
          gap = (exp_q[0][FLIT_W+1:FLIT_W] == 2'b11);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    idle(0);
    chk("rst_rdy", out_req_rdy, 1);
    chk("rst_v", v_flit_out, 0);
    chk("rst_err", protocol_err, 0);

    // dc 4-flit packet, tail latency
    wr_pkt(3'b010, 4, 1);
    idle(1);
`ifndef OUT_REQ_CUT_THROUGH_EN
    chk("lat_t1_v", v_flit_out, 0);
`endif
    idle(1);
    chk("lat_t2_v", v_flit_out, 1);
    drain();

    // fill to full across pointer wrap, overflow attempt, then drain
    wr_pkt(3'b100, 4, 0);
    wr_pkt(3'b001, 4, 0);
    idle(0);
    chk("full_rdy", out_req_rdy, 0);
    step(1, 3'b010, 2'b01, 16'hdead, 0, acc);
    idle(0);
    chk("ovf_err", protocol_err, 1);
    drain();

    // stalls: toggle net_rdy every cycle mid-packet
    do_reset();
    wr_pkt(3'b001, 4, 0);
    for (int i = 0; i < 14; i++) idle(i[0]);
    drain();

    // tail write coinciding with tail pop
    do_reset();
    wr_pkt(3'b100, 2, 1);
    step(1, 3'b010, 2'b01, FLIT_W'($urandom), 1, acc);
    step(1, 3'b010, 2'b10, FLIT_W'($urandom), 1, acc);
    step(1, 3'b010, 2'b11, FLIT_W'($urandom), 1, acc);
`ifndef OUT_REQ_CUT_THROUGH_EN
    idle(1);
    idle(1);
    chk("b2b_next_head_v", v_flit_out, 1);
`endif
    drain();

`ifdef OUT_REQ_CUT_THROUGH_EN
    do_reset();
    step(1, 3'b010, 2'b01, 16'h1111, 1, acc);
    idle(1);
    chk("ct_t1_v", v_flit_out, 0);
    idle(1);
    chk("ct_t2_v", v_flit_out, 1);
    idle(1);
    chk("ct_empty_v", v_flit_out, 0);
    idle(1);
    chk("ct_empty_v2", v_flit_out, 0);
    step(1, 3'b010, 2'b10, 16'h2222, 1, acc);
    idle(1);
    chk("ct_body_v", v_flit_out, 1);
    step(1, 3'b010, 2'b11, 16'h3333, 1, acc);
    drain();
`endif

    // randomized traffic with occasional bad selects
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [2:0] s;
      bit a;
      a = ($urandom_range(99) < 60);
      if ($urandom_range(63) == 0) begin
        case ($urandom_range(4))
          0: s = 3'b000; 1: s = 3'b011; 2: s = 3'b101; 3: s = 3'b110; default: s = 3'b111;
        endcase
      end else s = 3'(1 << $urandom_range(2));
      step(a, s, next_ctrl(), FLIT_W'($urandom), $urandom_range(99) < 55, acc);
      if (acc) begin
        pos++;
        if (pos == len) begin pos = 0; len = $urandom_range(2, 4); end
      end
    end
    for (int i = 0; i < 100 && pos != 0; i++) begin
      step(1, 3'b001, next_ctrl(), FLIT_W'($urandom), 1, acc);
      if (acc) begin
        pos++;
        if (pos == len) pos = 0;
      end
    end
    drain();
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
